// File: rtl/result_serializer.sv
// Byte serializer for arithmetic-unit results: captures a word on done_i and
// streams it MSB-first over valid/ready. Optional checksum byte: RESULT_SER_CHECKSUM_EN.
module result_serializer #(
   parameter int WIDTH_P = 32
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               done_i,
   input  logic [WIDTH_P-1:0] result_i,
   output logic               valid_o,
   output logic [7:0]         data_o,
   input  logic               ready_i,
   output logic               busy_o,
   output logic               overflow_o
);

   localparam int NBYTES_LP = WIDTH_P / 8;
   localparam int CNT_W     = $clog2(NBYTES_LP) + 1;

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StSend = 2'd1;
`ifdef RESULT_SER_CHECKSUM_EN
   localparam logic [1:0] StCsum = 2'd2;
`endif

   logic [1:0]         state_q;
   logic [WIDTH_P-1:0] shreg_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               ovf_q;
   logic               hs;
   logic               last_data;
   logic               fin;
   logic               accept;

   assign hs        = valid_o & ready_i;
   assign last_data = (state_q == StSend) &&
                      (cnt_q == CNT_W'(NBYTES_LP - 1));

`ifdef RESULT_SER_CHECKSUM_EN
   logic [7:0] csum_q;

   function automatic logic [7:0] xor_bytes(input logic [WIDTH_P-1:0] w);
      logic [7:0] x;
      x = 8'h00;
      for (int i = 0; i < NBYTES_LP; i++) x ^= w[i*8 +: 8];
      return x;
   endfunction

   assign fin = hs && (state_q == StCsum);
`else
   assign fin = hs && last_data;
`endif

   // A new result is taken when idle or on the frame's closing handshake.
   assign accept = done_i && ((state_q == StIdle) || fin);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         shreg_q <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
`ifdef RESULT_SER_CHECKSUM_EN
         csum_q  <= 8'h00;
`endif
      end else begin
         if (done_i && !accept) ovf_q <= 1'b1;
         if (accept) begin
            state_q <= StSend;
            shreg_q <= result_i;
            cnt_q   <= '0;
`ifdef RESULT_SER_CHECKSUM_EN
            csum_q  <= xor_bytes(result_i);
`endif
         end else if (hs) begin
            case (state_q)
               StSend: begin
                  shreg_q <= shreg_q << 8;
                  cnt_q   <= cnt_q + 1'b1;
                  if (last_data) begin
`ifdef RESULT_SER_CHECKSUM_EN
                     state_q <= StCsum;
`else
                     state_q <= StIdle;
`endif
                  end
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   assign valid_o    = (state_q != StIdle);
   assign busy_o     = (state_q != StIdle);
   assign overflow_o = ovf_q;

   always_comb begin
      data_o = 8'h00;
      case (state_q)
         StSend: data_o = shreg_q[WIDTH_P-1 -: 8];
`ifdef RESULT_SER_CHECKSUM_EN
         StCsum: data_o = csum_q;
`endif
         default: data_o = 8'h00;
      endcase
   end

endmodule
